// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard and stall scheduler for a 5-stage RV32I pipeline.
//                Generates stage stall/flush controls, EX-stage forwarding
//                selects, a memory-wait watchdog FSM and a stall-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_S_RUN   = 2'd0;
    localparam logic [1:0] c_S_DWAIT = 2'd1;
    localparam logic [1:0] c_S_IWAIT = 2'd2;
    localparam logic [1:0] c_S_HALT  = 2'd3;

    localparam logic [WC_W-1:0] c_WAIT_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] c_WAIT_ONE  = WC_W'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [WC_W-1:0] r_wait_cnt;
    logic [WC_W-1:0] w_wait_nxt;
    logic            w_dmiss;
    logic            w_imiss;
    logic            w_lwstall;

    assign w_dmiss   = MemReqM && !dmem_ready;
    assign w_imiss   = !imem_ready;
    assign w_lwstall = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Forwarding selects: the younger producer in M wins over W; x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    // State register: the watchdog state and the length of the current wait run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Next-state logic: a dmem miss always restarts/continues a data wait, and a
    // switch between wait kinds restarts the run count at one.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            c_S_RUN: begin
                if (w_dmiss) begin
                    w_state_nxt = c_S_DWAIT;
                    w_wait_nxt  = c_WAIT_ONE;
                end else if (w_imiss) begin
                    w_state_nxt = c_S_IWAIT;
                    w_wait_nxt  = c_WAIT_ONE;
                end else begin
                    w_wait_nxt  = '0;
                end
            end
            c_S_DWAIT: begin
                if (!w_dmiss) begin
                    if (w_imiss) begin
                        w_state_nxt = c_S_IWAIT;
                        w_wait_nxt  = c_WAIT_ONE;
                    end else begin
                        w_state_nxt = c_S_RUN;
                        w_wait_nxt  = '0;
                    end
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = c_S_HALT;
                end else begin
                    w_wait_nxt  = r_wait_cnt + c_WAIT_ONE;
                end
            end
            c_S_IWAIT: begin
                if (w_dmiss) begin
                    w_state_nxt = c_S_DWAIT;
                    w_wait_nxt  = c_WAIT_ONE;
                end else if (!w_imiss) begin
                    w_state_nxt = c_S_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = c_S_HALT;
                end else begin
                    w_wait_nxt  = r_wait_cnt + c_WAIT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_HALT;
            end
        endcase
    end

    // Output logic: stall/flush controls follow the same-cycle conditions in
    // fixed priority; the FSM only contributes the HALT freeze.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            if ((r_state == c_S_HALT) || w_dmiss) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (w_imiss) begin
                StallF = 1'b1;
                FlushD = 1'b1;
            end
        end
    end

    assign halted = (r_state == c_S_HALT);

    // Performance counter: cycles with the fetch stage stalled, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (StallF && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall scheduler for the 5-stage RV32I pipeline.
- Drives stall and flush controls into the F, D, E, M and W pipeline registers, including the IF/ID register's StallD/FlushD.
- Generates EX-stage forwarding selects.
- Sequences multi-cycle instruction-memory and data-memory waits with a watchdog FSM and a stall-cycle performance counter.

Parameters:
TIMEOUT, 256, consecutive not-ready memory cycles that trigger HALT (must be ≥2).
CNT_W, 32, width of stall_cycles counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
Rs1D, Rs2D  in  5  source regs of instruction in D
Rs1E, Rs2E, RdE  in  5  source/dest regs in E
MemReadE  in  1  E instruction is a load
RdM  in  5  dest reg in M
RegWriteM  in  1  M writes register file
RdW  in  5  dest reg in W
RegWriteW  in  1  W writes register file
PCSrcE  in  1  taken branch/jump resolved in E
MemReqM  in  1  M instruction accesses dmem
dmem_ready  in  1  dmem completes this cycle
imem_ready  in  1  imem instruction valid this cycle
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  load bubble (zeros) into stage register
ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
halted  out  1  sticky watchdog halt
stall_cycles  out  CNT_W  count of cycles with StallF=1

Behaviour:
- Reset:
  - While rst=1, all stall/flush outputs and forwards are 0.
  - State=RUN, wait_cnt=0, halted=0, stall_cycles=0.
  - rst mid-wait or in HALT returns to RUN at the next edge.
- Forwarding (combinational, always active):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE is identical using Rs2E. M beats W.
- Conditions:
  - dmiss = MemReqM && !dmem_ready
  - imiss = !imem_ready
  - lwstall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)
- Stall/flush outputs are combinational from state and inputs, applied in this priority order:
  1. HALT state: StallF=StallD=StallE=StallM=1, FlushW=1, others 0.
  2. dmiss (freeze): StallF=StallD=StallE=StallM=1, FlushW=1. Branch, load-use and imiss are ignored this cycle.
  3. PCSrcE: FlushD=1, FlushE=1, StallF=0 (PC takes target even if imiss).
  4. lwstall: StallF=1, StallD=1, FlushE=1. FlushD=0 even if imiss.
  5. imiss: StallF=1, FlushD=1 (bubble into D).
  6. Otherwise all stall/flush outputs are 0.
- FSM (states RUN, DWAIT, IWAIT, HALT):
  - RUN:
    - dmiss → DWAIT, wait_cnt=1.
    - Else imiss → IWAIT, wait_cnt=1.
  - DWAIT:
    - dmem_ready=1 → RUN, wait_cnt=0. If imiss in the same cycle → IWAIT, wait_cnt=1.
    - Still dmiss: if wait_cnt==TIMEOUT-1 → HALT. Else wait_cnt+1.
  - IWAIT:
    - dmiss takes precedence → DWAIT, wait_cnt=1.
    - Else imem_ready=1 → RUN, wait_cnt=0.
    - Else if wait_cnt==TIMEOUT-1 → HALT. Else wait_cnt+1.
  - HALT: halted=1, sticky until rst. All inputs ignored.
  - The FSM only times waits; the stall outputs follow the input conditions in the same cycle.
- Timeout arithmetic:
  - HALT is entered on the edge ending the TIMEOUT-th consecutive not-ready cycle of one kind.
  - wait_cnt width is clog2(TIMEOUT)+1 bits.
- stall_cycles increments on each edge where StallF=1 and rst=0. It saturates at all-ones (no wrap).

Test Plan:
1. Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00. Repeat with RdM=0 → ForwardAE=01.
2. Load-use: MemReadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle. stall_cycles 0→1. Same with RdE=0 → no stall.
3. Branch vs load-use vs imiss: PCSrcE=1 with lwstall=1 and imem_ready=0 → FlushD=FlushE=1, StallF=StallD=0.
4. dmem freeze: MemReqM=1, dmem_ready low 3 cycles then high, PCSrcE=1 throughout. Required:
   - StallF/D/E/M=1, FlushW=1 and FlushD=FlushE=0 for 3 cycles.
   - 4th cycle: flushes from branch.
   - State RUN after the 4th edge; halted=0.
5. Watchdog, TIMEOUT=4: imem_ready=0 held → halted=1 after the 4th edge, all stalls asserted. imem_ready=1 then has no effect. rst for one cycle → halted=0, stall_cycles=0.
6. Counter saturation, CNT_W=4: hold imem_ready=0 with TIMEOUT=64 for 20 cycles → stall_cycles stops at 15.
